// File: rtl/usb_gpx_irq_pkg.sv
// Shared constants for the GPX interrupt controller: register map, CTRL/EDGE
// bit positions and the glitch-filter state encoding.
package usb_gpx_irq_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_CTRL  = 2'd1;
    localparam logic [1:0] ADDR_EDGE  = 2'd2;
    localparam logic [1:0] ADDR_EVCNT = 2'd3;

    localparam int IRQ_EN   = 0;
    localparam int RISE_EN  = 1;
    localparam int FALL_EN  = 2;
    localparam int FILT_LSB = 8;

    localparam int RISE = 0;
    localparam int FALL = 1;

    typedef enum logic {
        FILT_STABLE  = 1'b0,
        FILT_PENDING = 1'b1
    } filt_state_e;

endpackage

// File: rtl/usb_gpx_filter.sv
// Two-flop synchronizer plus glitch filter for the GPX pin. The filtered level
// only follows the synchronized pin after it has disagreed for filt_len+1 cycles.
module usb_gpx_filter
    import usb_gpx_irq_pkg::*;
#(
    parameter int FILTER_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_port,
    input  logic [FILTER_W-1:0] filt_len,
    input  logic                cnt_clr,
    output logic                sync2,
    output logic                filt_level,
    output logic                rise_pulse,
    output logic                fall_pulse
);

    logic                sync1;
    logic [FILTER_W-1:0] cnt;
    logic [FILTER_W-1:0] cnt_cur;
    filt_state_e         state;
    logic                mismatch;
    logic                level_upd;

    // cnt is only meaningful while PENDING; treat it as zero otherwise.
    assign mismatch   = (sync2 != filt_level);
    assign cnt_cur    = (state == FILT_PENDING) ? cnt : '0;
    assign level_upd  = mismatch && !cnt_clr && (cnt_cur == filt_len);
    assign rise_pulse = level_upd & sync2;
    assign fall_pulse = level_upd & ~sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            filt_level <= 1'b0;
            cnt        <= '0;
            state      <= FILT_STABLE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            if (!mismatch || cnt_clr) begin
                // A filt_len change restarts the count so an equality match cannot be skipped.
                cnt   <= '0;
                state <= mismatch ? FILT_PENDING : FILT_STABLE;
            end else if (level_upd) begin
                filt_level <= sync2;
                cnt        <= '0;
                state      <= FILT_STABLE;
            end else begin
                cnt   <= cnt_cur + FILTER_W'(1);
                state <= FILT_PENDING;
            end
        end
    end

endmodule

// File: rtl/usb_gpx_irq_ctrl.sv
// Avalon-MM slave wrapping the GPX pin: edge-enable control, sticky W1C edge
// flags, an edge counter and a level interrupt.
module usb_gpx_irq_ctrl
    import usb_gpx_irq_pkg::*;
#(
    parameter int                  FILTER_W   = 8,
    parameter logic [FILTER_W-1:0] FILTER_DEF = FILTER_W'(4),
    parameter int                  CNT_W      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    input  logic        in_port,
    output logic [31:0] readdata,
    output logic        irq
);

    // Bus protocol: a write is accepted on any edge with chipselect=1 and
    // write_n=0 (no wait states); readdata is registered from address every
    // cycle, so a read returns one cycle after the address is presented.
    logic                wr;
    logic                wr_ctrl;
    logic                wr_edge;
    logic                wr_evcnt;
    logic                irq_en;
    logic                rise_en;
    logic                fall_en;
    logic [FILTER_W-1:0] filt_len;
    logic                rise_flag;
    logic                fall_flag;
    logic [CNT_W-1:0]    evcnt;
    logic                sync2;
    logic                filt_level;
    logic                rise_pulse;
    logic                fall_pulse;
    logic                rise_cap;
    logic                fall_cap;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign wr       = chipselect & ~write_n;
    assign wr_ctrl  = wr && (address == ADDR_CTRL);
    assign wr_edge  = wr && (address == ADDR_EDGE);
    assign wr_evcnt = wr && (address == ADDR_EVCNT);
    assign rise_cap = rise_pulse & rise_en;
    assign fall_cap = fall_pulse & fall_en;
    assign unused_wdata = ^writedata;

    usb_gpx_filter #(
        .FILTER_W (FILTER_W)
    ) u_filter (
        .clk        (clk),
        .reset      (reset),
        .in_port    (in_port),
        .filt_len   (filt_len),
        .cnt_clr    (wr_ctrl),
        .sync2      (sync2),
        .filt_level (filt_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en    <= 1'b0;
            rise_en   <= 1'b0;
            fall_en   <= 1'b0;
            filt_len  <= FILTER_DEF;
            rise_flag <= 1'b0;
            fall_flag <= 1'b0;
            evcnt     <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
        end else begin
            if (wr_ctrl) begin
                irq_en   <= writedata[IRQ_EN];
                rise_en  <= writedata[RISE_EN];
                fall_en  <= writedata[FALL_EN];
                filt_len <= writedata[FILT_LSB +: FILTER_W];
            end
            // A new edge overrides a same-cycle W1C of its flag.
            rise_flag <= (rise_flag & ~(wr_edge & writedata[RISE])) | rise_cap;
            fall_flag <= (fall_flag & ~(wr_edge & writedata[FALL])) | fall_cap;
            if (rise_cap || fall_cap) begin
                evcnt <= wr_evcnt ? CNT_W'(1) : evcnt + CNT_W'(1);
            end else if (wr_evcnt) begin
                evcnt <= '0;
            end
            irq      <= irq_en & (rise_flag | fall_flag);
            readdata <= rd_mux;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: begin
                rd_mux[0] = filt_level;
                rd_mux[1] = sync2;
            end
            ADDR_CTRL: begin
                rd_mux[IRQ_EN]                = irq_en;
                rd_mux[RISE_EN]               = rise_en;
                rd_mux[FALL_EN]               = fall_en;
                rd_mux[FILT_LSB +: FILTER_W]  = filt_len;
            end
            ADDR_EDGE: begin
                rd_mux[RISE] = rise_flag;
                rd_mux[FALL] = fall_flag;
            end
            ADDR_EVCNT: rd_mux[CNT_W-1:0] = evcnt;
            default: rd_mux = '0;
        endcase
    end

endmodule

// File: tb/tb_usb_gpx_irq_ctrl.sv
// Bench for usb_gpx_irq_ctrl: directed scenarios plus randomized pulse trains
// checked against a segment-length model of the glitch filter.
module tb_usb_gpx_irq_ctrl;
    import usb_gpx_irq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    logic        m_level;
    logic        m_rise;
    logic        m_fall;
    int unsigned m_cnt;

    usb_gpx_irq_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        address = a;
        @(posedge clk); #1;
        d = readdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        logic [31:0] d;
        in_port = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = ADDR_DATA; writedata = '0; reset = 1'b1;
        tick(3);
        n_vec++;
        if (irq !== 1'b0 || readdata !== 32'h0) begin
            n_err++; $display("FAIL reset_outputs: irq=%b readdata=%h, want irq=0 readdata=0", irq, readdata);
        end
        reset = 1'b0;
        tick(10);
        bus_read(ADDR_DATA, d);
        n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL reset_data: got %h want 00000003", d); end
        bus_read(ADDR_CTRL, d);
        n_vec++; if (d !== 32'h400) begin n_err++; $display("FAIL reset_ctrl: got %h want 00000400", d); end
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_edge: got %h want 00000000", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_evcnt: got %h want 00000000", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_ctrl_rw;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'hFFFF_FFFF);
        bus_read(ADDR_CTRL, d);
        n_vec++; if (d !== 32'h0000_FF07) begin n_err++; $display("FAIL ctrl_rw: got %h want 0000ff07", d); end
        bus_write(ADDR_CTRL, 32'h0000_0400);
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL ctrl_rw_edge: got %h want 00000000", d); end
    endtask

    task automatic test_rise_timing;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0000_0403);
        in_port = 1'b0;
        tick(12);
        in_port = 1'b1;            // sampled at edge k
        tick(7);                   // just after k+6
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_early: got %b want 0 at k+6", irq); end
        tick(1);                   // just after k+7
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rise_irq_k7: got %b want 1 at k+7", irq); end
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL rise_edge: got %h want 00000001", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL rise_evcnt: got %h want 00000001", d); end
        bus_write(ADDR_EDGE, 32'h1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL w1c_irq_hold: got %b want 1 on write edge", irq); end
        tick(1);
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq_drop: got %b want 0", irq); end
    endtask

    task automatic test_glitch;
        logic [31:0] d;
        bus_write(ADDR_EVCNT, 32'h0);
        in_port = 1'b0;
        tick(12);
        in_port = 1'b1;
        tick(3);
        in_port = 1'b0;
        tick(12);
        bus_read(ADDR_DATA, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_data: got %h want 00000000", d); end
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_edge: got %h want 00000000", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL glitch_evcnt: got %h want 00000000", d); end
    endtask

    task automatic test_fall_square;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0000_0404);
        bus_write(ADDR_EVCNT, 32'h0);
        bus_write(ADDR_EDGE, 32'h3);
        for (int i = 0; i < 5; i++) begin
            in_port = 1'b1; tick(10);
            in_port = 1'b0; tick(10);
        end
        tick(10);
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL square_edge: got %h want 00000002", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h5) begin n_err++; $display("FAIL square_evcnt: got %h want 00000005", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL square_irq: got %b want 0", irq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0000_0403);
        bus_write(ADDR_EDGE, 32'h3);
        bus_write(ADDR_EVCNT, 32'h0);
        in_port = 1'b1; tick(12);
        in_port = 1'b0; tick(12);
        in_port = 1'b1;
        tick(5);
        bus_write(ADDR_EDGE, 32'h1);   // lands on the capture edge
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL b2b_irq_edge: got %b want 1", irq); end
        tick(1);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL b2b_irq_after: got %b want 1", irq); end
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL b2b_edge: got %h want 00000001", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h2) begin n_err++; $display("FAIL b2b_evcnt: got %h want 00000002", d); end
        in_port = 1'b0; tick(12);
        in_port = 1'b1;
        tick(5);
        bus_write(ADDR_EVCNT, 32'h0);  // lands on the capture edge
        tick(2);
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h1) begin n_err++; $display("FAIL b2b_evcnt_clr: got %h want 00000001", d); end
    endtask

    task automatic test_random;
        logic [31:0] d;
        int          lens[$];
        int          fl;
        int          en;
        int          nseg;
        int          hold;
        int          eff;
        logic        v;
        for (int r = 0; r < 8; r++) begin
            fl   = $urandom_range(0, 5);
            en   = $urandom_range(0, 7);
            nseg = $urandom_range(4, 12);
            hold = fl + 6;
            bus_write(ADDR_CTRL, (32'(fl) << 8) | 32'(en));
            bus_write(ADDR_EDGE, 32'h3);
            bus_write(ADDR_EVCNT, 32'h0);
            m_level = in_port; m_rise = 1'b0; m_fall = 1'b0; m_cnt = 0;
            lens.delete();
            v = in_port;
            for (int s = 0; s < nseg; s++) begin
                v = ~v;
                lens.push_back($urandom_range(1, fl + 3));
                in_port = v;
                tick(lens[s]);
            end
            tick(hold);
            // a segment passes the filter only if it differs from the level for fl+1 cycles
            v = m_level;
            for (int s = 0; s < nseg; s++) begin
                v   = ~v;
                eff = lens[s] + ((s == nseg - 1) ? hold : 0);
                if (v != m_level && eff >= fl + 1) begin
                    m_level = v;
                    if (v && en[1]) begin m_rise = 1'b1; m_cnt = (m_cnt + 1) % 65536; end
                    if (!v && en[2]) begin m_fall = 1'b1; m_cnt = (m_cnt + 1) % 65536; end
                end
            end
            bus_read(ADDR_DATA, d);
            n_vec++; if (d !== (m_level ? 32'h3 : 32'h0)) begin n_err++; $display("FAIL rand%0d_data: got %h want level %b", r, d, m_level); end
            bus_read(ADDR_EDGE, d);
            n_vec++; if (d !== {30'b0, m_fall, m_rise}) begin n_err++; $display("FAIL rand%0d_edge: got %h want fall=%b rise=%b", r, d, m_fall, m_rise); end
            bus_read(ADDR_EVCNT, d);
            n_vec++; if (d !== 32'(m_cnt)) begin n_err++; $display("FAIL rand%0d_evcnt: got %h want %h", r, d, m_cnt); end
            n_vec++; if (irq !== (en[0] & (m_rise | m_fall))) begin n_err++; $display("FAIL rand%0d_irq: got %b want %b", r, irq, en[0] & (m_rise | m_fall)); end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0000_0006);
        bus_write(ADDR_EVCNT, 32'h0);
        bus_write(ADDR_EDGE, 32'h3);
        for (int i = 0; i < 65535; i++) begin
            in_port = ~in_port;
            tick(1);
        end
        tick(5);
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h0000_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h want 0000ffff", d); end
        in_port = ~in_port;
        tick(5);
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL wrap_evcnt: got %h want 00000000", d); end
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL wrap_flags: got %h want 00000003", d); end
    endtask

    task automatic test_reset_pending;
        logic [31:0] d;
        bus_write(ADDR_CTRL, 32'h0000_0802);
        bus_write(ADDR_EDGE, 32'h3);
        bus_write(ADDR_EVCNT, 32'h0);
        in_port = 1'b0; tick(20);
        in_port = 1'b1; tick(5);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        tick(15);
        bus_read(ADDR_EDGE, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rstpend_edge: got %h want 00000000", d); end
        bus_read(ADDR_EVCNT, d);
        n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL rstpend_evcnt: got %h want 00000000", d); end
        bus_read(ADDR_CTRL, d);
        n_vec++; if (d !== 32'h400) begin n_err++; $display("FAIL rstpend_ctrl: got %h want 00000400", d); end
        bus_read(ADDR_DATA, d);
        n_vec++; if (d !== 32'h3) begin n_err++; $display("FAIL rstpend_data: got %h want 00000003", d); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rstpend_irq: got %b want 0", irq); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset;
        test_ctrl_rw;
        test_rise_timing;
        test_glitch;
        test_fall_square;
        test_back_to_back;
        test_random;
        test_wrap;
        test_reset_pending;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
